// File: rtl/int_to_fp32_pkg.sv
// Shared types and constants for the integer to binary32 conversion pipeline.
package int_to_fp32_pkg;

    localparam int unsigned FP32_BIAS  = 127;
    localparam int unsigned FP32_MAN_W = 23;
    localparam int unsigned FP32_EXP_W = 8;
    localparam int unsigned IN_W       = 64;
    localparam int unsigned LZ_W       = 7;
    // Exponent of a value whose leading one sits at bit IN_W-1.
    localparam int unsigned EXP_TOP    = FP32_BIAS + IN_W - 1;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic            sign;
        logic [IN_W-1:0] mag;
    } s1_t;

    // frac drops the implicit leading one of the normalized magnitude.
    typedef struct packed {
        logic            sign;
        logic            zero;
        logic [LZ_W-1:0] lz;
        logic [IN_W-2:0] frac;
    } s2_t;

endpackage

// File: rtl/int_to_fp32_if.sv
// Valid/ready input and output channels of the integer to binary32 converter.
interface int_to_fp32_if;
    import int_to_fp32_pkg::*;

    logic                i_in_valid;
    logic                o_in_ready;
    logic [IN_W-1:0]     i_in_data;
    logic                i_in_wide;
    logic                i_in_signed;
    logic                o_out_valid;
    logic                i_out_ready;
    logic [31:0]         o_out_data;
    logic                o_inexact;
    logic                o_zero;

    modport slave (
        input  i_in_valid, i_in_data, i_in_wide, i_in_signed, i_out_ready,
        output o_in_ready, o_out_valid, o_out_data, o_inexact, o_zero
    );

    modport master (
        output i_in_valid, i_in_data, i_in_wide, i_in_signed, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_data, o_inexact, o_zero
    );

endinterface

// File: rtl/int_to_fp32_converter_lzc64.sv
// Combinational 64-bit leading-zero counter; an all-zero input yields 64.
module lzc64
    import int_to_fp32_pkg::*;
(
    input  logic [IN_W-1:0] i_data,
    output logic [LZ_W-1:0] o_count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_count = LZ_W'(IN_W);
        for (int i = 0; i < int'(IN_W); i++) begin
            if (i_data[i]) begin
                o_count = LZ_W'(int'(IN_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_fp32_converter.sv
// Three-stage int/longint to binary32 converter, round-to-nearest-even,
// with a single pipeline enable driven by output back-pressure.
module int_to_fp32_converter
    import int_to_fp32_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    int_to_fp32_if.slave  bus
);

    logic            en_c;
    logic            v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
    s1_t             s1_c, s1_d, s1_q;
    s2_t             s2_c, s2_d, s2_q;
    fp32_t           res_c, out_d, out_q;
    logic            inexact_c, inexact_d, inexact_q;
    logic            zero_d, zero_q;
    logic [IN_W-1:0] ext_c;
    logic [LZ_W-1:0] lz_c;
    logic [IN_W-1:0] norm_c;

    logic [FP32_MAN_W-1:0] man_c;
    logic                  guard_c, sticky_c, up_c;
    logic [FP32_MAN_W:0]   man_rnd_c;
    logic [FP32_EXP_W-1:0] exp_c;

    assign en_c           = !out_valid_q || bus.i_out_ready;
    assign bus.o_in_ready = en_c;

    // S1: extend the 32-bit operand if needed and take the magnitude.
    always_comb begin
        ext_c = bus.i_in_wide ? bus.i_in_data
              : {{32{bus.i_in_signed & bus.i_in_data[31]}}, bus.i_in_data[31:0]};
        s1_c.sign = bus.i_in_signed & ext_c[IN_W-1];
        s1_c.mag  = s1_c.sign ? (~ext_c + IN_W'(1)) : ext_c;
    end

    lzc64 u_lzc (
        .i_data  (s1_q.mag),
        .o_count (lz_c)
    );

    // S2: normalize so the leading one lands at bit 63, then drop it.
    always_comb begin
        norm_c    = s1_q.mag << lz_c;
        s2_c.sign = s1_q.sign;
        s2_c.zero = (s1_q.mag == '0);
        s2_c.lz   = lz_c;
        s2_c.frac = norm_c[IN_W-2:0];
    end

    // S3: round to nearest-even; a mantissa carry bumps the exponent.
    always_comb begin
        man_c     = s2_q.frac[62:40];
        guard_c   = s2_q.frac[39];
        sticky_c  = |s2_q.frac[38:0];
        up_c      = guard_c & (sticky_c | man_c[0]);
        man_rnd_c = {1'b0, man_c} + {{FP32_MAN_W{1'b0}}, up_c};
        exp_c     = FP32_EXP_W'(EXP_TOP - 32'(s2_q.lz))
                  + FP32_EXP_W'(man_rnd_c[FP32_MAN_W]);
        res_c     = '{sign: s2_q.sign, exp: exp_c, man: man_rnd_c[FP32_MAN_W-1:0]};
        inexact_c = guard_c | sticky_c;
        if (s2_q.zero) begin
            res_c     = '0;
            inexact_c = 1'b0;
        end
    end

    always_comb begin
        v1_d        = v1_q;
        v2_d        = v2_q;
        out_valid_d = out_valid_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_d       = out_q;
        inexact_d   = inexact_q;
        zero_d      = zero_q;
        if (en_c) begin
            v1_d        = bus.i_in_valid;
            v2_d        = v1_q;
            out_valid_d = v2_q;
            s1_d        = s1_c;
            s2_d        = s2_c;
            out_d       = res_c;
            inexact_d   = inexact_c;
            zero_d      = s2_q.zero;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_q       <= '0;
            inexact_q   <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_q       <= out_d;
            inexact_q   <= inexact_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_data  = out_q;
    assign bus.o_inexact   = inexact_q;
    assign bus.o_zero      = zero_q;

endmodule
